// File: rtl/regbank_alu_pipe.sv
// Four-stage register-bank ALU pipeline (RF capture, EX, WB, ST) with debug read ports.
// Optional operand forwarding is enabled by defining REGBANK_ALU_FORWARD_EN.
module regbank_alu_pipe #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int ADDR_W = 8,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [REG_AW-1:0] r1,
   input  logic [REG_AW-1:0] r2,
   input  logic [REG_AW-1:0] rd,
   input  logic [FUNC_W-1:0] func,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] f,
   output logic              f_valid,
   input  logic [REG_AW-1:0] dbg_reg_sel,
   output logic [DATA_W-1:0] dbg_reg_data,
   input  logic [ADDR_W-1:0] dbg_mem_addr,
   output logic [DATA_W-1:0] dbg_mem_data
);
   localparam int NREG = 2**REG_AW;
   localparam int NMEM = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] mem  [NMEM];

   // Operands captured at acceptance; the ALU works on these during the next cycle.
   logic              ex_valid_reg;
   logic [DATA_W-1:0] ex_a_reg, ex_b_reg;
   logic [REG_AW-1:0] ex_rd_reg;
   logic [FUNC_W-1:0] ex_func_reg;
   logic [ADDR_W-1:0] ex_addr_reg;

   logic              wb_valid_reg;
   logic [DATA_W-1:0] wb_z_reg;
   logic [REG_AW-1:0] wb_rd_reg;
   logic [ADDR_W-1:0] wb_addr_reg;

   logic              st_valid_reg;
   logic [DATA_W-1:0] st_z_reg;
   logic [ADDR_W-1:0] st_addr_reg;

   logic [DATA_W-1:0] f_reg;
   logic              f_valid_reg;

   logic [DATA_W-1:0] alu_z;
   logic [DATA_W-1:0] opnd_a_next, opnd_b_next;

   always_comb begin
      alu_z = '0;
      case (int'(ex_func_reg))
         0:  alu_z = ex_a_reg + ex_b_reg;
         1:  alu_z = ex_a_reg - ex_b_reg;
         2:  alu_z = ex_a_reg * ex_b_reg;
         3:  alu_z = ex_a_reg;
         4:  alu_z = ex_b_reg;
         5:  alu_z = ex_a_reg & ex_b_reg;
         6:  alu_z = ex_a_reg | ex_b_reg;
         7:  alu_z = ex_a_reg ^ ex_b_reg;
         8:  alu_z = -ex_a_reg;
         9:  alu_z = -ex_b_reg;
         10: alu_z = ex_a_reg >> 1;
         11: alu_z = ex_b_reg >> 1;
         12: alu_z = DATA_W'(ex_addr_reg);
         default: alu_z = '0;
      endcase
   end

`ifdef REGBANK_ALU_FORWARD_EN
   // Later assignments take priority, so the youngest producer (EX) wins over WB.
   always_comb begin
      opnd_a_next = regs[r1];
      opnd_b_next = regs[r2];
      if (wb_valid_reg && wb_rd_reg == r1) opnd_a_next = wb_z_reg;
      if (wb_valid_reg && wb_rd_reg == r2) opnd_b_next = wb_z_reg;
      if (ex_valid_reg && ex_rd_reg == r1) opnd_a_next = alu_z;
      if (ex_valid_reg && ex_rd_reg == r2) opnd_b_next = alu_z;
   end
`else
   always_comb begin
      opnd_a_next = regs[r1];
      opnd_b_next = regs[r2];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg <= 1'b0;
         wb_valid_reg <= 1'b0;
         st_valid_reg <= 1'b0;
         f_valid_reg  <= 1'b0;
         f_reg        <= '0;
      end else begin
         ex_valid_reg <= in_valid;
         wb_valid_reg <= ex_valid_reg;
         st_valid_reg <= wb_valid_reg;
         f_valid_reg  <= wb_valid_reg;
         if (wb_valid_reg) f_reg <= wb_z_reg;
      end
   end

   // Payload registers need no reset: the valid bits alone gate every write.
   always_ff @(posedge clk) begin
      ex_a_reg    <= opnd_a_next;
      ex_b_reg    <= opnd_b_next;
      ex_rd_reg   <= rd;
      ex_func_reg <= func;
      ex_addr_reg <= addr;
      wb_z_reg    <= alu_z;
      wb_rd_reg   <= ex_rd_reg;
      wb_addr_reg <= ex_addr_reg;
      st_z_reg    <= wb_z_reg;
      st_addr_reg <= wb_addr_reg;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) regs[i] <= '0;
         else if (wb_valid_reg && wb_rd_reg == REG_AW'(i)) regs[i] <= wb_z_reg;
      end
   end

   // A store due on the reset edge belongs to a discarded instruction and is dropped.
   always_ff @(posedge clk) begin
      if (!rst && st_valid_reg) mem[st_addr_reg] <= st_z_reg;
   end

   assign f            = f_reg;
   assign f_valid      = f_valid_reg;
   assign dbg_reg_data = regs[dbg_reg_sel];
   assign dbg_mem_data = mem[dbg_mem_addr];
endmodule

// File: tb/tb_regbank_alu_pipe.sv
// Randomised self-checking bench for regbank_alu_pipe against an instruction-level model.
module tb_regbank_alu_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  r1 = '0, r2 = '0, rd = '0, func = '0;
   logic [7:0]  addr = '0;
   logic [15:0] f;
   logic        f_valid;
   logic [3:0]  dbg_reg_sel = '0;
   logic [15:0] dbg_reg_data;
   logic [7:0]  dbg_mem_addr = '0;
   logic [15:0] dbg_mem_data;

   always #5 clk = ~clk;

   regbank_alu_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .r1(r1), .r2(r2), .rd(rd),
      .func(func), .addr(addr), .f(f), .f_valid(f_valid),
      .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
      .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
   );

`ifdef REGBANK_ALU_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {int cyc; logic [3:0] rd; logic [15:0] z;} pend_t;
   typedef struct {int cyc; logic [15:0] z;} fev_t;
   typedef struct {int cyc; logic [7:0] ad; logic [15:0] z;} memw_t;

   pend_t       pend_q[$];
   fev_t        f_q[$];
   memw_t       mem_q[$];
   logic [15:0] arch [16];
   logic [15:0] mem_m [256];
   bit          mem_known [256];
   logic [15:0] f_exp = '0;
   bit          fv_exp = 1'b0;
   bit          live = 1'b0;
   int          edge_n = 0;
   int          n_pass = 0;
   int          n_chk = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] ref_alu(input logic [3:0] fn, input logic [15:0] a,
                                           input logic [15:0] b, input logic [7:0] ad);
      longint ai = longint'(a);
      longint bi = longint'(b);
      longint r;
      case (fn)
         4'd0:  r = (ai + bi) % 65536;
         4'd1:  r = (ai - bi + 65536) % 65536;
         4'd2:  r = (ai * bi) % 65536;
         4'd3:  r = ai;
         4'd4:  r = bi;
         4'd5:  r = longint'(a & b);
         4'd6:  r = longint'(a | b);
         4'd7:  r = longint'(a ^ b);
         4'd8:  r = (65536 - ai) % 65536;
         4'd9:  r = (65536 - bi) % 65536;
         4'd10: r = ai / 2;
         4'd11: r = bi / 2;
         4'd12: r = longint'(ad);
         default: r = 0;
      endcase
      return 16'(r);
   endfunction

   // Forwarding build: newest in-flight result wins; otherwise the committed register.
   function automatic logic [15:0] read_reg(input logic [3:0] idx);
      if (FWD) begin
         for (int k = pend_q.size() - 1; k >= 0; k--)
            if (pend_q[k].rd == idx) return pend_q[k].z;
      end
      return arch[idx];
   endfunction

   always @(posedge clk) begin
      logic [15:0] a, b, z;
      edge_n++;
      if (rst) begin
         live = 1'b1;
         pend_q.delete(); f_q.delete(); mem_q.delete();
         for (int i = 0; i < 16; i++) arch[i] = '0;
         f_exp = '0;
         fv_exp = 1'b0;
      end else if (live) begin
         while (mem_q.size() > 0 && mem_q[0].cyc == edge_n) begin
            mem_m[mem_q[0].ad] = mem_q[0].z;
            mem_known[mem_q[0].ad] = 1'b1;
            void'(mem_q.pop_front());
         end
         fv_exp = 1'b0;
         if (f_q.size() > 0 && f_q[0].cyc == edge_n) begin
            f_exp = f_q[0].z;
            fv_exp = 1'b1;
            void'(f_q.pop_front());
         end
         if (in_valid) begin
            a = read_reg(r1);
            b = read_reg(r2);
            z = ref_alu(func, a, b, addr);
            pend_q.push_back('{edge_n, rd, z});
            f_q.push_back('{edge_n + 2, z});
            mem_q.push_back('{edge_n + 3, addr, z});
         end
         while (pend_q.size() > 0 && pend_q[0].cyc <= edge_n - 2) begin
            arch[pend_q[0].rd] = pend_q[0].z;
            void'(pend_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("f_valid", {15'd0, f_valid}, {15'd0, fv_exp});
         chk("f", f, f_exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] fn, input logic [3:0] a_i,
                        input logic [3:0] b_i, input logic [3:0] d_i, input logic [7:0] ad);
      in_valid = v; func = fn; r1 = a_i; r2 = b_i; rd = d_i; addr = ad;
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic peek_reg(input logic [3:0] idx, input logic [15:0] exp, input string name);
      dbg_reg_sel = idx;
      #0.1;
      chk(name, dbg_reg_data, exp);
   endtask

   task automatic peek_mem(input logic [7:0] ad, input logic [15:0] exp, input string name);
      dbg_mem_addr = ad;
      #0.1;
      chk(name, dbg_mem_data, exp);
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      peek_reg(4'd0, 16'd0, "reset_reg0");
      chk("reset_f", f, 16'd0);

      // Back-to-back dependent chain
      drive(1, 4'd12, 4'd0, 4'd0, 4'd1, 8'd3);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd2, 8'd5);
      drive(1, 4'd0,  4'd1, 4'd2, 4'd10, 8'd125);
      idle(2);
      chk("chain_f", f, FWD ? 16'd8 : 16'd0);
      chk("chain_fv", {15'd0, f_valid}, 16'd1);
      idle(1);
      peek_mem(8'd125, FWD ? 16'd8 : 16'd0, "chain_mem125");
      peek_reg(4'd10, FWD ? 16'd8 : 16'd0, "chain_reg10");

      // Independent subtract
      drive(1, 4'd12, 4'd0, 4'd0, 4'd3, 8'd3);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd5, 8'd5);
      idle(3);
      drive(1, 4'd1, 4'd3, 4'd5, 4'd12, 8'd60);
      idle(2);
      chk("sub_f", f, 16'hFFFE);

      // Multiply wrap and negate
      drive(1, 4'd12, 4'd0, 4'd0, 4'd6, 8'd200);
      idle(3);
      drive(1, 4'd2, 4'd6, 4'd6, 4'd11, 8'd61);
      drive(1, 4'd8, 4'd6, 4'd0, 4'd13, 8'd62);
      idle(1);
      chk("mul_f", f, 16'd40000);
      idle(1);
      chk("neg_f", f, 16'hFF38);

      // Seed memory words used by later boundary checks
      drive(1, 4'd0,  4'd6, 4'd6, 4'd9,  8'd200);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd8,  8'd50);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd14, 8'd77);
      idle(3);

      // Bubbles between valid slots
      drive(1, 4'd12, 4'd0, 4'd0, 4'd15, 8'd7);
      drive(0, 4'd12, 4'd0, 4'd0, 4'd15, 8'd77);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd15, 8'd9);
      chk("bub_f7", f, 16'd7);
      drive(0, 4'd12, 4'd0, 4'd0, 4'd15, 8'd77);
      chk("bub_hold", f, 16'd7);
      chk("bub_fv0", {15'd0, f_valid}, 16'd0);
      idle(1);
      chk("bub_f9", f, 16'd9);
      idle(2);
      peek_mem(8'd77, 16'd77, "bub_mem77");

      // Reset while an instruction is in flight
      drive(1, 4'd12, 4'd0, 4'd0, 4'd4, 8'd33);
      idle(3);
      drive(1, 4'd12, 4'd0, 4'd0, 4'd4, 8'd200);
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      idle(4);
      chk("rst_f", f, 16'd0);
      peek_reg(4'd4, 16'd0, "rst_reg4");
      peek_mem(8'd200, 16'd400, "rst_mem200");

      // Reserved function code yields zero
      drive(1, 4'd12, 4'd0, 4'd0, 4'd7, 8'd44);
      idle(3);
      drive(1, 4'd13, 4'd1, 4'd2, 4'd7, 8'd50);
      idle(2);
      chk("f13_f", f, 16'd0);
      idle(1);
      peek_mem(8'd50, 16'd0, "f13_mem50");
      peek_reg(4'd7, 16'd0, "f13_reg7");

      // Random traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         r1       = 4'($urandom_range(0, 15));
         r2       = 4'($urandom_range(0, 15));
         rd       = 4'($urandom_range(0, 15));
         func     = 4'($urandom_range(0, 15));
         addr     = 8'($urandom_range(0, 255));
         tick();
      end
      rst = 1'b0;
      idle(5);
      for (int i = 0; i < 16; i++) peek_reg(4'(i), arch[i], "sweep_reg");
      for (int i = 0; i < 256; i++)
         if (mem_known[i]) peek_mem(8'(i), mem_m[i], "sweep_mem");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
